booth_mult_seq: RTL
===================

Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier with a start/busy/done handshake.
- Retires one Booth step per clock. Produces a full-width two's-complement product of two WIDTH-bit operands.
- Generalises the fixed 8-bit, free-running multiplier: configurable width, resettable state, explicit operand capture, and a completion strobe.
- Sits on the datapath next to the ALU; the controller issues start and waits for done.

Parameters:
WIDTH, 8, operand width in bits; legal values 4..32; product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+2), iteration counter width; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when busy=0
m  input  WIDTH  multiplicand; captured on the accepting edge
q  input  WIDTH  multiplier; captured on the accepting edge
busy  output  1  high while an operation is in progress
done  output  1  single-cycle completion strobe
product  output  2*WIDTH  result; held until the next completion

Behaviour:
- Reset (async, rst=1):
  - State becomes IDLE.
  - busy=0, done=0, product=0.
  - Internal accumulator, multiplier shift register and counter all clear.
  - Reset mid-operation aborts the operation; no done is generated.
- States: IDLE, RUN.
- IDLE:
  - done drops to 0 one cycle after it pulsed.
  - With start=1 at edge E0:
    - Capture M = m sign-extended to WIDTH+1 bits.
    - Load Q = q and q_1 = 0.
    - Clear accumulator A (WIDTH+1 bits).
    - Load count = WIDTH.
    - Move to RUN; busy=1 from E0.
- RUN, each edge:
  - Booth step:
    - If {Q[0],q_1} = 2'b10: A = A - M.
    - If {Q[0],q_1} = 2'b01: A = A + M.
    - Otherwise A is unchanged.
  - Arithmetic right shift of {A,Q,q_1} by one; A's MSB is replicated.
  - Decrement count.
- Accumulator width:
  - A is WIDTH+1 bits so that M = -2^(WIDTH-1) cannot overflow.
  - Product = low 2*WIDTH bits of {A,Q} after the final shift; A's extra MSB is discarded.
- Completion:
  - The edge performing the WIDTH-th step is E0+WIDTH.
  - On that edge: product is registered, done=1 for exactly one cycle, busy=0, and the state returns to IDLE.
  - Latency from the accepting edge to done: WIDTH cycles.
- start while busy=1 is ignored; operands are not re-sampled.
- Back-to-back operation:
  - start=1 in the cycle done=1 is accepted, since busy=0.
  - The new operation begins; product keeps the previous result until the new completion.
- Operand inputs may change freely after the accepting edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
BOOTH_UNSIGNED_EN
- Defined:
  - Adds input port sgn (1 bit), sampled together with start.
  - sgn=1: behaviour identical to the signed mode above.
  - sgn=0: m and q are zero-extended to WIDTH+1 bits. The Q register widens to WIDTH+1 bits and WIDTH+1 steps are run, so latency is WIDTH+1 cycles.
  - sgn=0 result: the unsigned product, exact in 2*WIDTH bits.
- Undefined:
  - No sgn port.
  - Signed only, with fixed latency WIDTH.

Test Plan:
- WIDTH=8, m=3, q=5, start one cycle -> busy high 8 cycles; done single pulse at edge E0+8; product=16'd15.
- WIDTH=8, corner signed products, one operation per pair:
  - m=-128, q=-128 -> product=16'h4000.
  - m=-128, q=127 -> product=16'hC080 (-16256).
  - m=-1, q=1 -> product=16'hFFFF.
- WIDTH=8 ordering and hold rules:
  - start with (7,6), then start again during busy with (2,2) -> second request ignored; product=42.
  - Back-to-back start in the done cycle with (-3,9) -> product=42 holds until the next done; then product=-27 (16'hFFE5).
- WIDTH=8, rst pulsed 3 cycles into an operation -> busy=0, done never pulses, product=0; the next start (4,4) gives 16.
- WIDTH=16, m=16'h8000, q=16'h7FFF, plus 200 random signed pairs checked against a reference multiply -> latency exactly 16 cycles each.
- BOOTH_UNSIGNED_EN defined, WIDTH=8, sgn=0, m=255, q=255 -> done at E0+9; product=16'd65025. With sgn=1 and the same operands -> product=16'd1.

Source files
------------

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, one Booth step per clock.
//
// Multiplies two WIDTH-bit two's-complement operands into a 2*WIDTH-bit product.
// The controller raises start while busy=0. The operands are captured on that
// edge. done pulses for one cycle WIDTH clocks later, and product then holds the
// result until the next completion.
//
// Optional build macro: BOOTH_UNSIGNED_EN
//   Adds the sgn input, which is sampled together with start.
//   sgn=1 gives signed operation.
//   sgn=0 gives an unsigned multiply with latency WIDTH+1.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset; aborts any operation in flight
//   start   request, sampled only while busy=0
//   sgn     (BOOTH_UNSIGNED_EN only) 1 = signed operands, 0 = unsigned operands
//   m       multiplicand (WIDTH bits)
//   q       multiplier (WIDTH bits)
//   busy    high while an operation is in progress
//   done    single-cycle completion strobe
//   product 2*WIDTH-bit result, registered
module booth_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 sgn,
`endif
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // The accumulator has one guard bit, so subtracting M = -2^(WIDTH-1) cannot overflow.
  localparam int AW = WIDTH + 1;
`ifdef BOOTH_UNSIGNED_EN
  // The unsigned mode needs a zero-extended multiplier, so it needs one extra step.
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam int SW = AW + QW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_reg, state_next;
  logic [AW-1:0]        a_reg, a_next;
  logic [AW-1:0]        m_reg, m_next;
  logic [QW-1:0]        q_reg, q_next;
  logic                 q1_reg, q1_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [2*WIDTH-1:0]   product_reg, product_next;
`ifdef BOOTH_UNSIGNED_EN
  logic                 sgn_reg, sgn_next;
`endif

  logic [AW-1:0]        a_step;
  logic [SW-1:0]        shift_vec;
  logic [2*WIDTH-1:0]   prod_sel;

  // Booth add/subtract, followed by an arithmetic right shift of {A,Q,q_1}.
  // shift_vec is the shifted register: A's MSB is replicated and the old q_1 drops out.
  always_comb begin
    a_step = a_reg;
    case ({q_reg[0], q1_reg})
      2'b10:   a_step = a_reg - m_reg;
      2'b01:   a_step = a_reg + m_reg;
      default: a_step = a_reg;
    endcase
    shift_vec = {a_step[AW-1], a_step, q_reg};
`ifdef BOOTH_UNSIGNED_EN
    // In signed mode only WIDTH steps run through a WIDTH+1-bit Q.
    // The product therefore sits one bit higher in {A,Q}.
    prod_sel = sgn_reg ? shift_vec[2*WIDTH+1:2] : shift_vec[2*WIDTH:1];
`else
    prod_sel = shift_vec[2*WIDTH:1];
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    m_next       = m_reg;
    q_next       = q_reg;
    q1_next      = q1_reg;
    cnt_next     = cnt_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    product_next = product_reg;
`ifdef BOOTH_UNSIGNED_EN
    sgn_next     = sgn_reg;
`endif
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          a_next     = '0;
          q1_next    = 1'b0;
          busy_next  = 1'b1;
          state_next = RUN;
`ifdef BOOTH_UNSIGNED_EN
          sgn_next = sgn;
          if (sgn) begin
            m_next   = {m[WIDTH-1], m};
            q_next   = {q[WIDTH-1], q};
            cnt_next = CNT_W'(WIDTH);
          end else begin
            m_next   = {1'b0, m};
            q_next   = {1'b0, q};
            cnt_next = CNT_W'(WIDTH + 1);
          end
`else
          m_next   = {m[WIDTH-1], m};
          q_next   = q;
          cnt_next = CNT_W'(WIDTH);
`endif
        end
      end
      RUN: begin
        a_next   = shift_vec[SW-1:QW+1];
        q_next   = shift_vec[QW:1];
        q1_next  = shift_vec[0];
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          product_next = prod_sel;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      q1_reg      <= 1'b0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
`ifdef BOOTH_UNSIGNED_EN
      sgn_reg     <= 1'b1;
`endif
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      m_reg       <= m_next;
      q_reg       <= q_next;
      q1_reg      <= q1_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      product_reg <= product_next;
`ifdef BOOTH_UNSIGNED_EN
      sgn_reg     <= sgn_next;
`endif
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule
